bp_fe_bp_update_queue: RTL

BP_FE_BP_UPDATE_QUEUE -- requirements
Module: bp_fe_bp_update_queue

---
 rtl/bp_fe_bp_update_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bp_fe_bp_update_queue.sv
// In-flight branch queue between fetch and backend: returns the predictor read
// to fetch, remembers {index, prediction}, and issues a one-cycle-late update on resolve.
module bp_fe_bp_update_queue #(
    parameter int bht_idx_width_p = 4,
    parameter int queue_els_p     = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               fetch_v_i,
    input  logic [bht_idx_width_p-1:0]         fetch_idx_i,
    output logic                               fetch_ready_o,
    output logic                               fetch_pred_o,
    output logic                               r_v_o,
    output logic [bht_idx_width_p-1:0]         idx_r_o,
    input  logic                               predict_i,
    input  logic                               resolve_v_i,
    input  logic                               resolve_taken_i,
    output logic                               resolve_ready_o,
    input  logic                               flush_i,
    output logic                               w_v_o,
    output logic [bht_idx_width_p-1:0]         idx_w_o,
    output logic                               correct_o,
    output logic                               mispredict_o,
    output logic [$clog2(queue_els_p):0]       count_o,
    output logic                               underflow_o
);

    localparam int lg_els_lp = $clog2(queue_els_p);
    localparam int ptr_w_lp  = lg_els_lp + 1;

    logic [ptr_w_lp-1:0]        wptr_r, rptr_r;
    logic [ptr_w_lp-1:0]        wptr_next_s, rptr_next_s;
    logic [bht_idx_width_p-1:0] idx_mem_r [queue_els_p];
    logic                       pred_mem_r [queue_els_p];

    logic                       full_s, empty_s;
    logic                       fetch_ready_s, fetch_hs_s, resolve_hs_s;
    logic [bht_idx_width_p-1:0] rd_idx_s;
    logic                       rd_pred_s, correct_next_s;

    logic                       w_v_r, mispredict_r, correct_r, underflow_r;
    logic [bht_idx_width_p-1:0] idx_w_r;

    // Occupancy, handshakes and next-pointer selection.
    always_comb begin
        full_s         = (wptr_r[lg_els_lp-1:0] == rptr_r[lg_els_lp-1:0]) &&
                         (wptr_r[lg_els_lp] != rptr_r[lg_els_lp]);
        empty_s        = (wptr_r == rptr_r);
        fetch_ready_s  = ~full_s & ~flush_i;
        fetch_hs_s     = fetch_v_i & fetch_ready_s;
        resolve_hs_s   = resolve_v_i & ~empty_s;
        rd_idx_s       = idx_mem_r[rptr_r[lg_els_lp-1:0]];
        rd_pred_s      = pred_mem_r[rptr_r[lg_els_lp-1:0]];
        correct_next_s = (resolve_taken_i == rd_pred_s);

        if (fetch_hs_s) begin
            wptr_next_s = wptr_r + ptr_w_lp'(1);
        end else begin
            wptr_next_s = wptr_r;
        end

        // Flush drops everything behind the same-cycle resolve, which still completes.
        if (flush_i) begin
            rptr_next_s = wptr_next_s;
        end else if (resolve_hs_s) begin
            rptr_next_s = rptr_r + ptr_w_lp'(1);
        end else begin
            rptr_next_s = rptr_r;
        end
    end

    // Queue pointers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            wptr_r <= wptr_next_s;
            rptr_r <= rptr_next_s;
        end
    end

    // Entry storage; left unreset because it is never read while empty.
    always_ff @(posedge clk_i) begin
        if (fetch_hs_s) begin
            idx_mem_r[wptr_r[lg_els_lp-1:0]]  <= fetch_idx_i;
            pred_mem_r[wptr_r[lg_els_lp-1:0]] <= predict_i;
        end
    end

    // Registered predictor update and sticky underflow flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_r        <= 1'b0;
            mispredict_r <= 1'b0;
            idx_w_r      <= '0;
            correct_r    <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            w_v_r        <= resolve_hs_s;
            mispredict_r <= resolve_hs_s & ~correct_next_s;
            if (resolve_hs_s) begin
                idx_w_r   <= rd_idx_s;
                correct_r <= correct_next_s;
            end
            underflow_r  <= underflow_r | (resolve_v_i & empty_s);
        end
    end

    assign fetch_ready_o   = fetch_ready_s;
    assign r_v_o           = fetch_hs_s;
    assign idx_r_o         = fetch_idx_i;
    assign fetch_pred_o    = predict_i & fetch_hs_s;
    assign resolve_ready_o = ~empty_s;
    assign count_o         = wptr_r - rptr_r;
    assign w_v_o           = w_v_r;
    assign idx_w_o         = idx_w_r;
    assign correct_o       = correct_r;
    assign mispredict_o    = mispredict_r;
    assign underflow_o     = underflow_r;

endmodule
